// File: rtl/imem_boot_ctrl.sv
// -----------------------------------------------------------------------------
// imem_boot_ctrl
//
// Owns the instruction memory array of a single-cycle CPU.
//   * Out of reset the whole array is zero-filled, one word per cycle.
//   * In RUN the CPU fetches combinationally: word address = cpu_pc[AW+1:2].
//   * On ld_start the array is cleared again and then a program image is
//     streamed in as bytes and packed big-endian (first byte -> [31:24]).
//   * The CPU is stalled and sees a nop (32'h0) whenever the clear/load
//     engine owns the array.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   cpu_pc / cpu_inst     fetch byte address in, fetched word out
//   cpu_stall             1 = CPU must not advance its PC
//   ld_start              one-cycle pulse requesting a program (re)load
//   ld_valid/ld_ready     byte handshake; ld_byte is the data, ld_last
//                         marks the final byte of the image
//   mem_addr/mem_wdata/   array port: write on rising clk when mem_we=1,
//   mem_we/mem_rdata      read data combinational from mem_addr
//   done                  one-cycle pulse after a load completes
//   err_overflow          sticky until next ld_start: image exceeded DEPTH
//   word_count            words written by the last load
// -----------------------------------------------------------------------------
module imem_boot_ctrl #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   cpu_pc,
  output logic [31:0]   cpu_inst,
  output logic          cpu_stall,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata,
  output logic          done,
  output logic          err_overflow,
  output logic [AW:0]   word_count
);

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0]    bc_q, bc_d;
  logic [23:0]   asm_q, asm_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW:0]   wc_q, wc_d;

  logic          we_c;
  logic [AW-1:0] addr_c;
  logic [31:0]   wdata_c;
  logic          stall_c;
  logic          ready_c;
  logic [31:0]   inst_c;

  // Only the word-index bits of the PC select a word.
  logic unused_pc;
  assign unused_pc = ^{cpu_pc[31:AW+2], cpu_pc[1:0]};

  // Left-justify the bytes gathered so far plus the current byte; a full
  // word (bc==3) is simply the concatenation.
  function automatic logic [31:0] pack_word(input logic [1:0]  bc,
                                            input logic [23:0] acc,
                                            input logic [7:0]  b);
    case (bc)
      2'd0:    pack_word = {b, 24'h0};
      2'd1:    pack_word = {acc[7:0], b, 16'h0};
      2'd2:    pack_word = {acc[15:0], b, 8'h0};
      default: pack_word = {acc, b};
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      bc_q    <= '0;
      asm_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bc_q    <= bc_d;
      asm_q   <= asm_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wc_q    <= wc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bc_d    = bc_q;
    asm_d   = asm_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    err_d   = err_q;
    wc_d    = wc_q;
    we_c    = 1'b0;
    addr_c  = ptr_q;
    wdata_c = 32'h0;
    stall_c = 1'b1;
    ready_c = 1'b0;
    inst_c  = 32'h0;

    case (state_q)
      ST_CLEAR: begin
        we_c  = 1'b1;
        ptr_d = ptr_q + 1'b1;
        // A request arriving mid-clear is remembered, never restarts the clear.
        if (ld_start) pend_d = 1'b1;
        if (ptr_q == LAST_ADDR) begin
          ptr_d   = '0;
          state_d = (pend_q || ld_start) ? ST_LOAD : ST_RUN;
        end
      end

      ST_RUN: begin
        addr_c  = cpu_pc[AW+1:2];
        inst_c  = mem_rdata;
        stall_c = 1'b0;
        if (ld_start) begin
          state_d = ST_CLEAR;
          pend_d  = 1'b1;
          err_d   = 1'b0;
          wc_d    = '0;
          ptr_d   = '0;
          bc_d    = '0;
        end
      end

      ST_LOAD: begin
        ready_c = 1'b1;
        if (ld_valid) begin
          if (wc_q == FULL_CNT) begin
            // Array full: drop the byte but keep consuming until ld_last.
            err_d = 1'b1;
          end else if (bc_q == 2'd3 || ld_last) begin
            we_c    = 1'b1;
            wdata_c = pack_word(bc_q, asm_q, ld_byte);
            ptr_d   = ptr_q + 1'b1;
            wc_d    = wc_q + 1'b1;
            bc_d    = '0;
          end else begin
            asm_d = {asm_q[15:0], ld_byte};
            bc_d  = bc_q + 1'b1;
          end
          if (ld_last) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            pend_d  = 1'b0;
            bc_d    = '0;
            ptr_d   = '0;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Reset forces the array port and CPU interface quiet immediately,
  // without waiting for a clock edge.
  assign mem_we       = we_c & ~rst;
  assign mem_addr     = addr_c;
  assign mem_wdata    = wdata_c;
  assign cpu_stall    = stall_c | rst;
  assign ld_ready     = ready_c & ~rst;
  assign cpu_inst     = rst ? 32'h0 : inst_c;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign word_count   = wc_q;

endmodule
